// File: rtl/led_shift_tx.sv
// Serializes a parallel word onto a shift-register LED chain: clear, clocked shift, latch.
// Frame length CLR_CYCLES + 2*CLK_DIV*DATA_W + CLK_DIV clocks; start is ignored while busy.
module led_shift_tx #(
  parameter int DATA_W       = 16,
  parameter int CLK_DIV      = 4,
  parameter int CLR_CYCLES   = 2,
  parameter int MSB_FIRST    = 1,
  parameter int AUTO_REFRESH = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              led_clk,
  output logic              led_do,
  output logic              led_clr,
  output logic              led_pen
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  // One phase counter serves the clear window, the bit period and the latch pulse.
  localparam int CNT_MAX = (CLR_CYCLES > 2 * CLK_DIV) ? CLR_CYCLES : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  logic [1:0]        state_q,   state_d;
  logic [DATA_W-1:0] sh_q,      sh_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [BIT_W-1:0]  bit_q,     bit_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              led_clk_q, led_clk_d;
  logic              led_do_q,  led_do_d;
  logic              led_clr_q, led_clr_d;
  logic              led_pen_q, led_pen_d;

  logic [DATA_W-1:0] sh_next;
  logic              accept;

  assign accept  = start || (AUTO_REFRESH != 0);
  assign sh_next = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    led_clk_d = led_clk_q;
    led_do_d  = led_do_q;
    led_clr_d = led_clr_q;
    led_pen_d = led_pen_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_CLEAR;
          sh_d      = sw;
          cnt_d     = '0;
          busy_d    = 1'b1;
          led_clr_d = 1'b0;
          led_clk_d = 1'b0;
          led_do_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          bit_d     = '0;
          led_clr_d = 1'b1;
          led_clk_d = 1'b0;
          led_do_d  = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // Data only moves at the end of a high phase, so led_do is stable across the rising edge.
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          led_clk_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            state_d   = ST_LATCH;
            led_do_d  = 1'b0;
            led_pen_d = 1'b1;
          end else begin
            bit_d    = bit_q + 1'b1;
            sh_d     = sh_next;
            led_do_d = (MSB_FIRST != 0) ? sh_next[DATA_W-1] : sh_next[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HALF_LAST) begin
            led_clk_d = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (cnt_q == HALF_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          led_pen_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_clk_q <= 1'b0;
      led_do_q  <= 1'b0;
      led_clr_q <= 1'b1;
      led_pen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      led_clk_q <= led_clk_d;
      led_do_q  <= led_do_d;
      led_clr_q <= led_clr_d;
      led_pen_q <= led_pen_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign led_clk = led_clk_q;
  assign led_do  = led_do_q;
  assign led_clr = led_clr_q;
  assign led_pen = led_pen_q;

endmodule

// File: tb/tb_led_shift_tx.sv
// Bench for led_shift_tx: three configurations (default, auto-refresh, LSB-first full-speed).
module tb_led_shift_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  start;
  logic [15:0] sw_v [3];
  wire  [2:0]  busy, done, lclk, ldo, lclr, lpen;

  led_shift_tx #(.DATA_W(16), .CLK_DIV(4), .CLR_CYCLES(2), .MSB_FIRST(1), .AUTO_REFRESH(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .sw(sw_v[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .led_clk(lclk[0]), .led_do(ldo[0]), .led_clr(lclr[0]), .led_pen(lpen[0]));

  led_shift_tx #(.DATA_W(16), .CLK_DIV(4), .CLR_CYCLES(2), .MSB_FIRST(1), .AUTO_REFRESH(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .sw(sw_v[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .led_clk(lclk[1]), .led_do(ldo[1]), .led_clr(lclr[1]), .led_pen(lpen[1]));

  led_shift_tx #(.DATA_W(16), .CLK_DIV(1), .CLR_CYCLES(1), .MSB_FIRST(0), .AUTO_REFRESH(0)) u_dut2 (
    .clk(clk), .reset(rst[2]), .sw(sw_v[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .led_clk(lclk[2]), .led_do(ldo[2]), .led_clr(lclr[2]), .led_pen(lpen[2]));

  // Per-instance timing parameters as the bench knows them.
  int p_div [3] = '{4, 4, 1};
  int p_clr [3] = '{2, 2, 1};

  typedef struct { int id; logic [15:0] word; int acc; } exp_t;
  typedef struct { int id; logic [15:0] word; int edges; int clr; int pen; int viol; int bsy; int cyc; } res_t;
  typedef struct { int id; logic [15:0] sw; logic [15:0] expw; } vec_t;

  exp_t exp_q[$];
  res_t res_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: observes the LED pins and reports one result record per done pulse.
  logic [2:0]  prev_clk = '0, prev_do = '0, prev_busy = '0;
  logic [15:0] cap [3];
  int edges [3], clr_lo [3], pen_hi [3], viol [3];
  int pen_idle [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        cap[i] = '0; edges[i] = 0; clr_lo[i] = 0; pen_hi[i] = 0; viol[i] = 0;
      end else begin
        if (busy[i] && !prev_busy[i]) begin
          cap[i] = '0; edges[i] = 0; clr_lo[i] = 0; pen_hi[i] = 0; viol[i] = 0;
        end
        if (!lclr[i]) begin
          clr_lo[i]++;
          if (lclk[i] || ldo[i]) viol[i]++;
        end
        if (lpen[i]) begin
          pen_hi[i]++;
          if (lclk[i] || ldo[i]) viol[i]++;
          if (!busy[i]) pen_idle[i]++;
        end
        if (lclk[i] && !prev_clk[i]) begin
          cap[i] = {cap[i][14:0], ldo[i]};
          edges[i]++;
        end
        if (lclk[i] && (ldo[i] != prev_do[i])) viol[i]++;
        if (done[i]) begin
          res_q.push_back('{i, cap[i], edges[i], clr_lo[i], pen_hi[i], viol[i], int'(busy[i]), cyc});
        end
      end
      prev_clk[i]  = lclk[i];
      prev_do[i]   = ldo[i];
      prev_busy[i] = busy[i];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_reset_vals(input int id, input string name);
    chk(name, int'({busy[id], done[id], lclk[id], ldo[id], lclr[id], lpen[id]}), 6'b000010);
  endtask

  task automatic start_frame(input int id, input logic [15:0] v, input logic [15:0] expw);
    sw_v[id]  = v;
    start[id] = 1'b1;
    exp_q.push_back('{id, expw, cyc + 1});
    step();
    start[id] = 1'b0;
    chk("accept_busy", int'(busy[id]), 1);
  endtask

  // Scoreboard pop: waits (bounded) for the next frame result and compares it.
  task automatic wait_frame(input string name);
    int   n = 0;
    res_t r;
    exp_t e;
    while (res_q.size() == 0 && n < 400) begin
      step();
      n++;
    end
    if (res_q.size() == 0) begin
      chk({name, "_timeout"}, 0, 1);
    end else if (exp_q.size() == 0) begin
      r = res_q.pop_front();
      chk({name, "_unexpected_frame"}, 1, 0);
    end else begin
      r = res_q.pop_front();
      e = exp_q.pop_front();
      last_cyc = r.cyc;
      chk({name, "_inst"},  r.id,    e.id);
      chk({name, "_word"},  int'(r.word), int'(e.word));
      chk({name, "_edges"}, r.edges, 16);
      chk({name, "_clr"},   r.clr,   p_clr[e.id]);
      chk({name, "_pen"},   r.pen,   p_div[e.id]);
      chk({name, "_order"}, r.viol,  0);
      chk({name, "_busy"},  r.bsy,   0);
      if (e.acc >= 0)
        chk({name, "_latency"}, r.cyc - e.acc, p_clr[e.id] + 2 * p_div[e.id] * 16 + p_div[e.id]);
    end
  endtask

  vec_t vecs [10];

  initial begin
    int bad;
    int d1, d2, d3;

    vecs[0] = '{0, 16'h001F, 16'h001F};
    vecs[1] = '{0, 16'hA5A5, 16'hA5A5};
    vecs[2] = '{0, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{0, 16'h0000, 16'h0000};
    vecs[4] = '{0, 16'h8001, 16'h8001};
    vecs[5] = '{0, 16'h1234, 16'h1234};
    vecs[6] = '{2, 16'h8001, 16'h8001};
    vecs[7] = '{2, 16'h0001, 16'h8000};
    vecs[8] = '{2, 16'h0003, 16'hC000};
    vecs[9] = '{2, 16'h1234, 16'h2C48};

    rst   = 3'b111;
    start = 3'b000;
    for (int i = 0; i < 3; i++) sw_v[i] = '0;
    repeat (3) step();
    chk_reset_vals(0, "reset_dut0");
    chk_reset_vals(1, "reset_dut1");
    chk_reset_vals(2, "reset_dut2");
    rst[0] = 1'b0;
    rst[2] = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      start_frame(vecs[i].id, vecs[i].sw, vecs[i].expw);
      wait_frame($sformatf("vec%0d", i));
      step();
    end

    // sw change and start during a frame must not disturb it or queue another.
    start_frame(0, 16'h001F, 16'h001F);
    repeat (48) step();
    sw_v[0]  = 16'hFFFF;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_frame("iso");
    repeat (150) step();
    chk("iso_no_second", res_q.size(), 0);
    chk("iso_idle_busy", int'(busy[0]), 0);

    // Reset in the middle of SHIFT aborts without a latch pulse.
    start_frame(0, 16'h001F, 16'h001F);
    repeat (58) step();
    rst[0] = 1'b1;
    step();
    chk_reset_vals(0, "rst_mid_next_edge");
    step();
    step();
    rst[0] = 1'b0;
    exp_q.delete();
    bad = 0;
    repeat (20) begin
      step();
      if ({busy[0], done[0], lclk[0], ldo[0], lclr[0], lpen[0]} != 6'b000010) bad++;
    end
    chk("rst_idle_hold", bad, 0);
    chk("rst_no_done", res_q.size(), 0);
    chk("rst_no_pen", pen_idle[0], 0);
    start_frame(0, 16'hA5A5, 16'hA5A5);
    wait_frame("post_rst");

    // Auto-refresh: back-to-back frames, sw sampled only at each accept.
    sw_v[1] = 16'h0003;
    rst[1]  = 1'b0;
    exp_q.push_back('{1, 16'h0003, cyc + 1});
    exp_q.push_back('{1, 16'h0003, -1});
    exp_q.push_back('{1, 16'h0010, -1});
    wait_frame("auto1");
    d1 = last_cyc;
    repeat (40) step();
    sw_v[1] = 16'h0010;
    wait_frame("auto2");
    d2 = last_cyc;
    wait_frame("auto3");
    d3 = last_cyc;
    rst[1] = 1'b1;
    chk("auto_gap12", d2 - d1, 135);
    chk("auto_gap23", d3 - d2, 135);
    repeat (5) step();

    chk("pen_outside_frame", pen_idle[0] + pen_idle[1] + pen_idle[2], 0);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_shift_tx.md
Name: led_shift_tx

Overview:
- Downstream display stage: consumes a 16-bit parallel result word (zero-extended adder sum) and serializes it onto the board's shift-register LED chain via led_clk/led_do/led_clr/led_pen.
- Frame sequencer: clear, then shift DATA_W bits with generated serial clock, then latch pulse.
- Operates on single-shot start or continuous auto-refresh.

Parameters:
- DATA_W, 16: bits per frame; must be ≥ 2.
- CLK_DIV, 4: system clocks per led_clk half-period; must be ≥ 1.
- CLR_CYCLES, 2: clocks led_clr held low at frame start; must be ≥ 1.
- MSB_FIRST, 1: 1 shifts sw[DATA_W-1] first; 0 shifts sw[0] first.
- AUTO_REFRESH, 0: 1 starts a new frame automatically from IDLE, and start is don't-care.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- sw, input, DATA_W: parallel data word to display.
- start, input, 1: frame request; sampled only in IDLE.
- busy, output, 1: high from the accepting edge until the frame completes.
- done, output, 1: single-cycle pulse at frame completion.
- led_clk, output, 1: serial shift clock; data captured on its rising edge.
- led_do, output, 1: serial data.
- led_clr, output, 1: active-low chain clear.
- led_pen, output, 1: active-high latch/parallel-enable pulse.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values, effective at the first edge with reset=1: state IDLE, busy=0, done=0, led_clk=0, led_do=0, led_clr=1, led_pen=0. Shift register and counters are cleared.
- Reset mid-frame aborts immediately, with the same values on the next edge. No partial latch pulse is issued afterwards.
- States: IDLE, CLEAR, SHIFT, LATCH.
- IDLE:
  - Accept condition: start=1, or AUTO_REFRESH=1.
  - On the accepting edge: capture sw into the shift register, set busy=1, go to CLEAR.
  - sw is sampled only at this edge. Later sw changes do not affect the frame in flight.
- CLEAR:
  - led_clr=0 for exactly CLR_CYCLES clocks.
  - led_clk=0 and led_do=0 throughout.
  - Then go to SHIFT, with led_clr returning to 1.
- SHIFT:
  - Each bit period is 2*CLK_DIV clocks.
  - First CLK_DIV clocks: led_clk=0, led_do = current bit (MSB or LSB of the shift register per MSB_FIRST).
  - Next CLK_DIV clocks: led_clk=1, led_do held.
  - led_do changes only while led_clk=0. Each rising edge of led_clk lands mid-bit.
  - Bit counter runs 0..DATA_W-1. Exactly DATA_W rising edges of led_clk occur per frame.
  - After the last high phase: led_clk=0, go to LATCH.
- LATCH:
  - led_pen=1 for CLK_DIV clocks, with led_clk=0 and led_do=0.
  - Then go to IDLE.
  - In that same transition: done=1 for one cycle, busy=0.
- Frame timing:
  - done asserts exactly CLR_CYCLES + 2*CLK_DIV*DATA_W + CLK_DIV clocks after the accepting edge.
  - Defaults: 2 + 128 + 4 = 134.
- start while busy is ignored, with no queuing.
- Auto-refresh frames:
  - Back-to-back, with exactly one IDLE cycle between frames, namely the done cycle.
  - Next accept happens on the edge following done.
- start held high continuously with AUTO_REFRESH=0 behaves as auto-refresh.
- CLK_DIV=1 gives a full-speed led_clk at clk/2. Same ordering rules apply.
- Counter widths are sized from the parameters via $clog2. No wrap-around occurs within a frame.

Test Plan:
- Reset: assert reset 3 cycles during activity -> on the next edge busy=0, done=0, led_clk=0, led_do=0, led_clr=1, led_pen=0, and all stay there while start=0.
- Single frame with defaults: sw=16'h001F, pulse start -> led_clr low 2 cycles; 16 led_clk rising edges; bits sampled at those edges read 0000_0000_0001_1111 in order; led_pen high 4 cycles after the last bit; done 1 cycle at edge 134; busy low thereafter.
- Isolation: during the frame above, change sw to 16'hFFFF and pulse start at cycle 50 -> serialized data remains 16'h001F; no second frame starts.
- Reset mid-SHIFT: reset at cycle 60 -> reset values next edge, no led_pen pulse; then start with sw=16'hA5A5 -> complete clean frame with exactly 16 edges carrying A5A5.
- Auto-refresh: AUTO_REFRESH=1, sw=16'h0003 -> consecutive done pulses exactly 135 clocks apart; sw changed to 16'h0010 between frames appears in the next frame only.
- Corners: MSB_FIRST=0, CLK_DIV=1, CLR_CYCLES=1, sw=16'h8001 -> first and last serialized bits are 1, all others 0; led_clk toggles every clock in SHIFT; done at 1+32+1=34 clocks.
